// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the HI/LO multiply/divide controller.
// Holds the operation encodings seen on the E-stage op bus, the FSM state
// encodings and the width of the latency down-counter.
package md_pkg;

  // Operation codes driven by the E stage alongside the start request.
  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_MADD  = 3'd6,
    MD_MSUB  = 3'd7
  } md_op_e;

  // Controller states: idle, or timing out a multiply or a divide.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_e;

  // Width of the latency down-counter; enough for latencies up to 32.
  localparam int unsigned CNT_W = 5;

endpackage

// File: rtl/md_ctrl.sv
// md_ctrl: multi-cycle multiply/divide controller owning the HI/LO registers.
// The arithmetic result is computed combinationally when the request is
// accepted and parked in a pending register; a down-counter then models the
// unit latency, and the pending value is committed to HI/LO when it expires.
// Optional feature: define MD_CTRL_MADD_EN to accept MADD/MSUB, which add or
// subtract the signed product to/from the {HI,LO} value at request time.
module md_ctrl
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        md_use_d_i,
  output logic        busy_o,
  output logic        stall_md_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  // Counter load values: the busy window includes the cycle where the
  // counter reads zero, so the load is one less than the latency.
  localparam logic [CNT_W-1:0] MultLoad = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DivLoad  = CNT_W'(DIV_CYCLES - 1);

  md_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic [63:0]      pend_q;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        b_zero;
  logic [31:0] div_s_den;
  logic [31:0] div_u_den;
  logic [31:0] quo_mag;
  logic [31:0] rem_mag;
  logic [31:0] quo_s;
  logic [31:0] rem_s;
  logic [31:0] quo_u;
  logic [31:0] rem_u;
  logic [63:0] div_s_res;
  logic [63:0] div_u_res;
  logic        is_md_op;
`ifdef MD_CTRL_MADD_EN
  logic [63:0] acc_add;
  logic [63:0] acc_sub;
`endif

  // Products: sign-extending both operands to 64 bits gives the exact
  // two's-complement signed product in the low 64 bits of the multiply.
  always_comb begin
    prod_s = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
    prod_u = {32'd0, a_i} * {32'd0, b_i};
  end

  // Quotient/remainder: signed divide works on magnitudes, then the quotient
  // takes the XOR of the signs and the remainder the sign of the dividend;
  // a zero divisor is steered to 1 so the divider never sees it, and the
  // architectural divide-by-zero pattern is substituted afterwards.
  always_comb begin
    a_neg     = a_i[31];
    b_neg     = b_i[31];
    a_mag     = a_neg ? (~a_i + 32'd1) : a_i;
    b_mag     = b_neg ? (~b_i + 32'd1) : b_i;
    b_zero    = (b_i == 32'd0);
    div_s_den = b_zero ? 32'd1 : b_mag;
    div_u_den = b_zero ? 32'd1 : b_i;
    quo_mag   = a_mag / div_s_den;
    rem_mag   = a_mag % div_s_den;
    quo_s     = (a_neg ^ b_neg) ? (~quo_mag + 32'd1) : quo_mag;
    rem_s     = a_neg ? (~rem_mag + 32'd1) : rem_mag;
    quo_u     = a_i / div_u_den;
    rem_u     = a_i % div_u_den;
    div_s_res = b_zero ? {a_i, 32'hFFFF_FFFF} : {rem_s, quo_s};
    div_u_res = b_zero ? {a_i, 32'hFFFF_FFFF} : {rem_u, quo_u};
  end

`ifdef MD_CTRL_MADD_EN
  // Accumulate results are based on the HI/LO value at request time.
  always_comb begin
    acc_add = {hi_q, lo_q} + prod_s;
    acc_sub = {hi_q, lo_q} - prod_s;
  end
`endif

  // Flags op codes that start a multi-cycle operation (used for stalling).
  always_comb begin
    is_md_op = 1'b0;
    case (op_i)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: is_md_op = 1'b1;
`ifdef MD_CTRL_MADD_EN
      MD_MADD, MD_MSUB:                   is_md_op = 1'b1;
`endif
      default:                            is_md_op = 1'b0;
    endcase
  end

  // Main FSM: accepts requests in IDLE, times the operation, commits HI/LO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            case (op_i)
              MD_MULT: begin
                state_q <= ST_MUL;
                cnt_q   <= MultLoad;
                busy_q  <= 1'b1;
                pend_q  <= prod_s;
              end
              MD_MULTU: begin
                state_q <= ST_MUL;
                cnt_q   <= MultLoad;
                busy_q  <= 1'b1;
                pend_q  <= prod_u;
              end
              MD_DIV: begin
                state_q <= ST_DIV;
                cnt_q   <= DivLoad;
                busy_q  <= 1'b1;
                pend_q  <= div_s_res;
              end
              MD_DIVU: begin
                state_q <= ST_DIV;
                cnt_q   <= DivLoad;
                busy_q  <= 1'b1;
                pend_q  <= div_u_res;
              end
              MD_MTHI: hi_q <= a_i;
              MD_MTLO: lo_q <= a_i;
`ifdef MD_CTRL_MADD_EN
              MD_MADD: begin
                state_q <= ST_MUL;
                cnt_q   <= MultLoad;
                busy_q  <= 1'b1;
                pend_q  <= acc_add;
              end
              MD_MSUB: begin
                state_q <= ST_MUL;
                cnt_q   <= MultLoad;
                busy_q  <= 1'b1;
                pend_q  <= acc_sub;
              end
`endif
              default: ;
            endcase
          end
        end
        ST_MUL, ST_DIV: begin
          if (cnt_q == '0) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            hi_q    <= pend_q[63:32];
            lo_q    <= pend_q[31:0];
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;
  assign stall_md_o = md_use_d_i & (busy_q | (start_i & is_md_op));

endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl: scoreboard bench for md_ctrl. Expected {HI,LO} values are
// produced by a behavioural model when a request is driven, queued, and
// popped when the controller drops busy. All driving and sampling happen on
// the falling clock edge. Define MD_CTRL_MADD_EN to cover MADD/MSUB.
module tb_md_ctrl;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        mdUse = 1'b0;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad = 0;
  logic [63:0] sb[$];
  logic [63:0] archQ = 64'd0;

  always #5 clk = ~clk;

  md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start),
    .op_i       (op),
    .a_i        (a),
    .b_i        (b),
    .md_use_d_i (mdUse),
    .busy_o     (busy),
    .stall_md_o (stall),
    .hi_o       (hi),
    .lo_o       (lo)
  );

  // Behavioural model of the 64-bit {HI,LO} result of one operation.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x,
                                        input logic [31:0] y, input logic [63:0] acc);
    longint sp;
    longint unsigned up;
    int q;
    int r;
    sp = longint'($signed(x)) * longint'($signed(y));
    up = {32'd0, x} * {32'd0, y};
    case (o)
      MD_MULT:  return sp;
      MD_MULTU: return up;
      MD_DIV: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        q = $signed(x) / $signed(y);
        r = $signed(x) % $signed(y);
        return {r, q};
      end
      MD_DIVU: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
      MD_MADD: return acc + sp;
      MD_MSUB: return acc - sp;
      default: return acc;
    endcase
  endfunction

  // Drives one start pulse (left high until the next falling edge) and
  // updates the scoreboard / architectural model.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    bit accepted;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    accepted = (o <= MD_DIVU);
`ifdef MD_CTRL_MADD_EN
    if (o == MD_MADD || o == MD_MSUB) accepted = 1'b1;
`endif
    if (accepted) sb.push_back(model(o, x, y, archQ));
    else if (o == MD_MTHI) archQ[63:32] = x;
    else if (o == MD_MTLO) archQ[31:0] = x;
  endtask

  // Drops start and counts busy cycles until busy falls (bounded).
  task automatic waitDone(output int cyc);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc <= 40) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      bad++;
      $display("[TB] FAIL reset_state busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
    end
    mdUse = 1'b1; op = MD_MULT; start = 1'b1;
    #1;
    total++;
    if (stall !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_stall_mult got=%b want=1", stall);
    end
    op = MD_MTHI;
    #1;
    total++;
    if (stall !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_stall_mthi got=%b want=0", stall);
    end
    start = 1'b0; mdUse = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    archQ = 64'd0;
    sb.delete();
  endtask

  task automatic test_mtx();
    int cyc;
    issue(MD_MTHI, 32'h1234_5678, 32'd0);
    waitDone(cyc);
    issue(MD_MTLO, 32'h9ABC_DEF0, 32'd0);
    waitDone(cyc);
    total++;
    if (cyc !== 0 || {hi, lo} !== archQ) begin
      bad++;
      $display("[TB] FAIL mthi_mtlo busy_cycles=%0d hilo=%h want 0 and %h", cyc, {hi, lo}, archQ);
    end
  endtask

  task automatic test_mult();
    logic [2:0]  ops[4] = '{MD_MULT, MD_MULTU, MD_MULT, MD_MULTU};
    logic [31:0] as[4]  = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h8000_0000, 32'd12345};
    logic [31:0] bs[4]  = '{32'd3, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd6789};
    logic [63:0] exp;
    int cyc;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i]);
      // Old HI/LO must still be visible during the busy window.
      @(negedge clk);
      total++;
      if (busy !== 1'b1 || {hi, lo} !== archQ) begin
        bad++;
        $display("[TB] FAIL mult_hold[%0d] busy=%b hilo=%h want 1 and %h", i, busy, {hi, lo}, archQ);
      end
      start = 1'b0;
      cyc = 1;
      while (busy === 1'b1 && cyc <= 40) begin
        @(negedge clk);
        if (busy === 1'b1) cyc++;
      end
      exp = (sb.size() > 0) ? sb.pop_front() : 64'hX;
      archQ = exp;
      total++;
      if (cyc !== 5 || {hi, lo} !== exp) begin
        bad++;
        $display("[TB] FAIL mult[%0d] cycles=%0d hilo=%h want 5 and %h", i, cyc, {hi, lo}, exp);
      end
    end
  endtask

  task automatic test_div();
    logic [2:0]  ops[6] = '{MD_DIVU, MD_DIV, MD_DIV, MD_DIVU, MD_DIV, MD_DIV};
    logic [31:0] as[6]  = '{32'd100, 32'hFFFF_FFF9, 32'd5, 32'd77, 32'd7, 32'hFFFF_FFF9};
    logic [31:0] bs[6]  = '{32'd7, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
    logic [63:0] exp;
    int cyc;
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], as[i], bs[i]);
      waitDone(cyc);
      exp = (sb.size() > 0) ? sb.pop_front() : 64'hX;
      archQ = exp;
      total++;
      if (cyc !== 10 || {hi, lo} !== exp) begin
        bad++;
        $display("[TB] FAIL div[%0d] cycles=%0d hilo=%h want 10 and %h", i, cyc, {hi, lo}, exp);
      end
    end
  endtask

  task automatic test_stall();
    logic [63:0] exp;
    int cyc;
    int stallErrs;
    mdUse = 1'b1;
    issue(MD_DIVU, 32'd1000, 32'd33);
    #1;
    total++;
    if (stall !== 1'b1) begin
      bad++;
      $display("[TB] FAIL stall_start got=%b want=1", stall);
    end
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    stallErrs = 0;
    while (busy === 1'b1 && cyc <= 40) begin
      cyc++;
      if (stall !== 1'b1) stallErrs++;
      @(negedge clk);
    end
    total++;
    if (stallErrs !== 0 || cyc !== 10) begin
      bad++;
      $display("[TB] FAIL stall_busy low_cycles=%0d busy_cycles=%0d want 0 and 10", stallErrs, cyc);
    end
    total++;
    if (stall !== 1'b0) begin
      bad++;
      $display("[TB] FAIL stall_fall got=%b want=0", stall);
    end
    exp = (sb.size() > 0) ? sb.pop_front() : 64'hX;
    archQ = exp;
    total++;
    if ({hi, lo} !== exp) begin
      bad++;
      $display("[TB] FAIL stall_result hilo=%h want %h", {hi, lo}, exp);
    end
    mdUse = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp;
    int cyc;
    bit lateBusy;
    issue(MD_MULT, 32'd6, 32'd7);
    @(negedge clk);
    start = 1'b0;
    cyc = (busy === 1'b1) ? 1 : 0;
    @(negedge clk);
    if (busy === 1'b1) cyc++;
    op = MD_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (busy === 1'b1 && cyc <= 40) begin
      cyc++;
      @(negedge clk);
    end
    exp = (sb.size() > 0) ? sb.pop_front() : 64'hX;
    archQ = exp;
    total++;
    if (cyc !== 5 || {hi, lo} !== exp) begin
      bad++;
      $display("[TB] FAIL busy_ignore cycles=%0d hilo=%h want 5 and %h", cyc, {hi, lo}, exp);
    end
    lateBusy = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (busy !== 1'b0) lateBusy = 1'b1;
    end
    total++;
    if (lateBusy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL busy_ignore_late busy_seen=%b want 0", lateBusy);
    end
  endtask

  task automatic test_reset_abort();
    int cyc;
    bit lateBusy;
    issue(MD_MTLO, 32'd10, 32'd0);
    waitDone(cyc);
    issue(MD_MULT, 32'd3, 32'd4);
    sb.delete();
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || lo !== 32'd10) begin
      bad++;
      $display("[TB] FAIL abort_pre busy=%b lo=%h want 1 and 0000000a", busy, lo);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      bad++;
      $display("[TB] FAIL abort_reset busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
    end
    archQ = 64'd0;
    @(negedge clk);
    rst_n = 1'b1;
    lateBusy = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (busy !== 1'b0) lateBusy = 1'b1;
    end
    total++;
    if (lateBusy !== 1'b0 || {hi, lo} !== 64'd0) begin
      bad++;
      $display("[TB] FAIL abort_no_commit busy_seen=%b hilo=%h want 0 and 0", lateBusy, {hi, lo});
    end
  endtask

  task automatic test_madd();
    logic [63:0] exp;
    int cyc;
    issue(MD_MTLO, 32'd10, 32'd0);
    waitDone(cyc);
`ifdef MD_CTRL_MADD_EN
    begin
      logic [2:0]  ops[3] = '{MD_MADD, MD_MSUB, MD_MSUB};
      logic [31:0] as[3]  = '{32'd2, 32'd1, 32'd5};
      logic [31:0] bs[3]  = '{32'd3, 32'd4, 32'd5};
      for (int i = 0; i < 3; i++) begin
        issue(ops[i], as[i], bs[i]);
        waitDone(cyc);
        exp = (sb.size() > 0) ? sb.pop_front() : 64'hX;
        archQ = exp;
        total++;
        if (cyc !== 5 || {hi, lo} !== exp) begin
          bad++;
          $display("[TB] FAIL madd[%0d] cycles=%0d hilo=%h want 5 and %h", i, cyc, {hi, lo}, exp);
        end
      end
    end
`else
    issue(MD_MADD, 32'd2, 32'd3);
    waitDone(cyc);
    issue(MD_MSUB, 32'd1, 32'd4);
    waitDone(cyc);
    total++;
    if (cyc !== 0 || {hi, lo} !== archQ) begin
      bad++;
      $display("[TB] FAIL madd_disabled cycles=%0d hilo=%h want 0 and %h", cyc, {hi, lo}, archQ);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_mtx();
    test_mult();
    test_div();
    test_stall();
    test_back_to_back();
    test_reset_abort();
    test_madd();
    total++;
    if (sb.size() !== 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_leftover got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout got=running want=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
